// File: rtl/priority_enc_pkg.sv
// priority_enc_pkg: shared state and mode encodings for the priority encoder arbiter
package priority_enc_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
endpackage

// File: rtl/priority_encoder_arb_if.sv
// priority_encoder_arb_if: request/grant bundle between requesters (master) and arbiter (slave)
interface priority_encoder_arb_if #(parameter int N = 8);
  localparam int W = $clog2(N);
  logic enable;
  logic mode;
  logic [N-1:0] data_in;
  logic ack;
  logic [W-1:0] data_out;
  logic valid;
  logic [N-1:0] grant_onehot;
  modport master (output enable, mode, data_in, ack, input data_out, valid, grant_onehot);
  modport slave (input enable, mode, data_in, ack, output data_out, valid, grant_onehot);
endinterface

// File: rtl/prio_find_first.sv
// prio_find_first: first set bit strictly after ptr, searching a doubled vector so the scan wraps at N-1
module prio_find_first #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);
  logic [2*N-1:0] dbl;
  always_comb begin
    dbl = {req, req};
    for (int i = 0; i < N; i++) dbl[i] = (i <= int'(ptr)) ? 1'b0 : dbl[i];
    idx = '0;
    found = 1'b0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) begin
        found = 1'b1;
        idx = W'(i >= N ? i - N : i);
      end
    end
  end
endmodule

// File: rtl/priority_encoder_arb.sv
// priority_encoder_arb: registered N-way fixed/round-robin arbiter with grant hold until ack
module priority_encoder_arb
  import priority_enc_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input logic clk,
  input logic rst,
  priority_encoder_arb_if.slave bus
);
  state_t state_q, state_d;
  logic [W-1:0] data_out_q, data_out_d, last_ptr_q, last_ptr_d;
  logic [N-1:0] grant_q, grant_d, req_rev;
  logic valid_q, valid_d;
  logic [W-1:0] rr_idx, fx_idx, win, rr_ptr;
  logic rr_found, fx_found, arb;
  // While a grant is being acked, the search starts just after the acked index
  assign rr_ptr = (state_q == GRANT) ? data_out_q : last_ptr_q;
  always_comb for (int i = 0; i < N; i++) req_rev[i] = bus.data_in[N-1-i];
  prio_find_first #(.N(N)) u_rr (.req(bus.data_in), .ptr(rr_ptr), .idx(rr_idx), .found(rr_found));
  // Reversed vector with nothing masked: first set bit is the highest original index
  prio_find_first #(.N(N)) u_fx (.req(req_rev), .ptr(W'(N-1)), .idx(fx_idx), .found(fx_found));
  assign win = (bus.mode == MODE_RR) ? rr_idx : W'(N-1) - fx_idx;
  assign arb = bus.enable && (bus.mode == MODE_RR ? rr_found : fx_found);
  always_comb begin
    state_d = state_q;
    data_out_d = data_out_q;
    grant_d = grant_q;
    valid_d = valid_q;
    last_ptr_d = last_ptr_q;
    if (state_q == IDLE || bus.ack) begin
      last_ptr_d = (state_q == GRANT) ? data_out_q : last_ptr_q;
      state_d = arb ? GRANT : IDLE;
      valid_d = arb;
      data_out_d = arb ? win : '0;
      grant_d = arb ? {{(N-1){1'b0}}, 1'b1} << win : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_out_q <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      last_ptr_q <= W'(N-1);
    end else begin
      state_q <= state_d;
      data_out_q <= data_out_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      last_ptr_q <= last_ptr_d;
    end
  end
  assign bus.data_out = data_out_q;
  assign bus.grant_onehot = grant_q;
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_priority_encoder_arb.sv
// tb_priority_encoder_arb: directed + random stimulus, expected outputs queued by a reference model
module tb_priority_encoder_arb;
  localparam int N = 8;
  typedef struct {logic v; logic [2:0] d; logic [N-1:0] g;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  bit m_valid = 1'b0;
  int m_idx = 0;
  int m_lp = N - 1;
  priority_encoder_arb_if #(.N(N)) bus();
  priority_encoder_arb #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic int pick(logic m, logic [N-1:0] d, int lp);
    int r = 0;
    bit hit = 0;
    if (!m) begin
      for (int i = 0; i < N; i++) if (d[i]) r = i;
    end else begin
      for (int k = 1; k <= N; k++) if (!hit && d[(lp + k) % N]) begin r = (lp + k) % N; hit = 1; end
    end
    return r;
  endfunction

  task automatic step(input logic r, input logic en, input logic m, input logic [N-1:0] din, input logic a);
    exp_t e;
    @(negedge clk);
    rst = r; bus.enable = en; bus.mode = m; bus.data_in = din; bus.ack = a;
    if (r) begin
      m_valid = 0; m_idx = 0; m_lp = N - 1;
    end else if (!m_valid || a) begin
      if (m_valid) m_lp = m_idx;
      if (en && din != 0) begin m_idx = pick(m, din, m_lp); m_valid = 1; end
      else begin m_idx = 0; m_valid = 0; end
    end
    e.v = m_valid;
    e.d = 3'(m_idx);
    e.g = m_valid ? N'(1) << m_idx : '0;
    sb.push_back(e);
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.valid !== e.v || bus.data_out !== e.d || bus.grant_onehot !== e.g) begin
          errors++;
          $display("FAIL grant t=%0t valid=%b data_out=%0d onehot=%h required valid=%b data_out=%0d onehot=%h",
                   $time, bus.valid, bus.data_out, bus.grant_onehot, e.v, e.d, e.g);
        end
      end
    end
  end

  initial begin
    bus.enable = 0; bus.mode = 0; bus.data_in = '0; bus.ack = 0;
    step(1, 1, 0, 8'hFF, 0);
    step(1, 1, 0, 8'hFF, 0);
    step(0, 1, 0, 8'b0010_0101, 0);
    repeat (3) step(0, 1, 0, 8'h80, 0);
    step(0, 1, 0, 8'h80, 1);
    step(0, 1, 0, 8'h00, 1);
    step(1, 0, 1, 8'h00, 0);
    repeat (10) step(0, 1, 1, 8'hFF, 1);
    repeat (4) step(0, 1, 1, 8'b1000_0001, 1);
    repeat (3) step(0, 1, 0, 8'b1000_0001, 1);
    step(0, 0, 1, 8'hFF, 1);
    step(0, 0, 1, 8'hFF, 0);
    step(0, 0, 1, 8'hFF, 1);
    step(0, 1, 1, 8'h08, 0);
    step(1, 1, 1, 8'h08, 0);
    step(0, 1, 1, 8'hFF, 0);
    repeat (3000) begin
      int p = $urandom_range(0, 3);
      logic [N-1:0] d = N'($urandom);
      if (p == 0) d = N'(1) << $urandom_range(0, N - 1);
      if (p == 1) d = d & N'($urandom);
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 8, 1'($urandom), d, 1'($urandom));
    end
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
